byte_serial_logic_unit: RTL and testbench
=========================================

# byte_serial_logic_unit

Multi-cycle bitwise logic unit for the MIPS32 datapath. It accepts two 32-bit operands and an opcode through a valid/ready handshake, then evaluates AND/OR/XOR/NOR/NOT one byte per cycle using a single 8-bit slice. It returns the result through a valid/ready handshake. It sits beside the ALU as the area-reduced logical-op path (AND/ANDI, OR/ORI, XOR/XORI, NOR, NOT pseudo-op) and is stalled by the pipeline control via the handshakes.

## Interface
- `WIDTH`, default 32: operand/result width in bits; must be a multiple of 8; slice count `NB = WIDTH/8`.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_valid` input, 1 bit: request present.
- `in_ready` output, 1 bit: unit can accept a request.
- `op` input, 3 bits: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 NOT a, 101 pass a, 11x reserved (result 0).
- `a` input, WIDTH bits: operand A.
- `b` input, WIDTH bits: operand B (ignored for ops 100/101).
- `out_valid` output, 1 bit: result available.
- `out_ready` input, 1 bit: consumer takes the result.
- `result` output, WIDTH bits: computed value; meaningful only while `out_valid`=1.
- `zero` output, 1 bit: result==0; present only with `BSLU_ZERO_FLAG_EN`.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, latch `a`, `b`, `op`; clear byte counter `idx`=0; go to RUN.
  - RUN: slice computes byte `idx` from the latched operands; `result[8*idx+:8]` is written; `idx` increments. When `idx`==NB-1 is written, go to DONE.
  - DONE: `out_valid`=1; `result` held stable. On `out_ready`=1, go to IDLE.
- `in_ready` = (state==IDLE); `out_valid` = (state==DONE). Both are decoded from registered state, with no combinational path from inputs.
- Inputs are ignored outside IDLE. Operand changes after acceptance have no effect.
- Reserved op: every byte evaluates to 8'h00; the handshake is otherwise normal.
- `idx` width is clog2(NB), minimum 1. It never wraps past NB-1; RUN exits on the last byte.
- Reset values, applied at the first `clk` edge with `rst`=1:
  - state = IDLE, `idx`=0, `result`=0, latched operands=0.
  - `out_valid`=0, `in_ready`=1, `zero`=1.
- Reset mid-RUN or in DONE: the operation is abandoned with no output. The next cycle is IDLE.
- `rst` has priority over every handshake event in the same cycle.

## Timing
- Request accepted at edge T, bytes 0..NB-1 written at edges T+1..T+NB, `out_valid` high after edge T+NB. For WIDTH=32, latency is 4 cycles.
- DONE lasts at least 1 cycle. `in_ready` rises the cycle after the `out_valid`&&`out_ready` edge. Peak throughput is one op per NB+2 cycles (6 for WIDTH=32).
- `out_ready` held low: stays in DONE indefinitely; `result`/`zero` are stable.
- `in_valid` and `out_ready` may both be high; only the one legal in the current state takes effect.

## Configuration
- `BSLU_ZERO_FLAG_EN` defined: adds the `zero` port, registered.
  - Set to 1 on accept.
  - ANDed with (written byte==0) on each RUN write.
  - Valid while `out_valid`=1.
  - Reset value 1.
- Not defined: no `zero` port and no flag register. All other behaviour is identical.

## Structure
- Shared package `logic_unit_pkg`:
  - op encodings as named constants (`LOP_AND`..`LOP_PASS`).
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Default `WIDTH`.
- Sub-module `bit8_logic_slice`: purely combinational 8-bit slice with inputs a[7:0], b[7:0], op[2:0] and output z[7:0], implementing all ops including NOT/NOR. Instantiated once and muxed by `idx`.
- The top level holds the FSM, counter, operand/result registers and optional flag.

## Test plan
- Reset, then a=32'h0F0F_00FF, b=32'hFFFF_0F0F, op=AND → after 4 cycles `out_valid`=1, `result`=32'h0F0F_000F, `zero`=0.
- op=NOT, a=32'hFFFF_FFFF → `result`=32'h0000_0000, `zero`=1. Then op=NOR, a=b=0 → `result`=32'hFFFF_FFFF.
- XOR a=32'h1234_5678, b=32'hFFFF_0000 with `out_ready`=0 for 10 cycles → `result`=32'hEDCB_5678 held stable and `in_ready`=0 throughout. `in_ready`=1 the cycle after `out_ready` is raised.
- Back-to-back requests with `in_valid` held high and `out_ready`=1 → accepts spaced exactly 6 cycles. `a` is changed during RUN, and each result matches the operands latched at its own accept.
- `rst` asserted at RUN byte 2 of an OR → next cycle: IDLE, `out_valid`=0, `result`=0, `in_ready`=1. A following request completes correctly.
- op=3'b110 with a=b=32'hFFFF_FFFF → `result`=0 after 4 cycles with a normal handshake.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the byte-serial logic unit: op encodings, FSM states, default width.
package logic_unit_pkg;

   localparam int DEFAULT_WIDTH = 32;

   localparam logic [2:0] LOP_AND  = 3'b000;
   localparam logic [2:0] LOP_OR   = 3'b001;
   localparam logic [2:0] LOP_XOR  = 3'b010;
   localparam logic [2:0] LOP_NOR  = 3'b011;
   localparam logic [2:0] LOP_NOT  = 3'b100;
   localparam logic [2:0] LOP_PASS = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Byte counter width: clog2 of the slice count, but never narrower than one bit.
   function automatic int idx_width(input int nb);
      return (nb > 1) ? $clog2(nb) : 1;
   endfunction

endpackage

// File: rtl/bit8_logic_slice.sv
// Combinational 8-bit logic slice shared across all bytes of an operation.
module bit8_logic_slice
   import logic_unit_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [2:0] op,
   output logic [7:0] z
);

   always_comb begin
      z = 8'h00;
      case (op)
         LOP_AND:  z = a & b;
         LOP_OR:   z = a | b;
         LOP_XOR:  z = a ^ b;
         LOP_NOR:  z = ~(a | b);
         LOP_NOT:  z = ~a;
         LOP_PASS: z = a;
         default:  z = 8'h00;
      endcase
   end

endmodule

// File: rtl/byte_serial_logic_unit.sv
// Byte-serial AND/OR/XOR/NOR/NOT/pass unit with valid/ready handshakes on both sides.
// Optional registered zero flag output enabled by defining BSLU_ZERO_FLAG_EN.
module byte_serial_logic_unit
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result
`ifdef BSLU_ZERO_FLAG_EN
   ,
   output logic             zero
`endif
);

   localparam int NB    = WIDTH / 8;
   localparam int IDX_W = idx_width(NB);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

   state_t           state_reg;
   logic [IDX_W-1:0] idx_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [2:0]       op_reg;
   logic [WIDTH-1:0] result_reg;
   logic             in_ready_reg;
   logic             out_valid_reg;

   logic [7:0] a_bytes [NB];
   logic [7:0] b_bytes [NB];
   logic [7:0] slice_a;
   logic [7:0] slice_b;
   logic [7:0] slice_z;

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_bytes
         assign a_bytes[gi] = a_reg[8*gi +: 8];
         assign b_bytes[gi] = b_reg[8*gi +: 8];
      end
   endgenerate

   assign slice_a = a_bytes[idx_reg];
   assign slice_b = b_bytes[idx_reg];

   bit8_logic_slice u_slice (
      .a  (slice_a),
      .b  (slice_b),
      .op (op_reg),
      .z  (slice_z)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         idx_reg       <= '0;
         a_reg         <= '0;
         b_reg         <= '0;
         op_reg        <= LOP_AND;
         result_reg    <= '0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (in_valid) begin
                  a_reg        <= a;
                  b_reg        <= b;
                  op_reg       <= op;
                  idx_reg      <= '0;
                  state_reg    <= ST_RUN;
                  in_ready_reg <= 1'b0;
               end
            end
            ST_RUN: begin
               for (int i = 0; i < NB; i++) begin
                  if (idx_reg == IDX_W'(i)) begin
                     result_reg[8*i +: 8] <= slice_z;
                  end
               end
               // The counter parks on the last byte instead of wrapping.
               if (idx_reg == LAST_IDX) begin
                  state_reg     <= ST_DONE;
                  out_valid_reg <= 1'b1;
               end else begin
                  idx_reg <= idx_reg + IDX_W'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_reg     <= ST_IDLE;
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
               end
            end
            default: begin
               state_reg     <= ST_IDLE;
               out_valid_reg <= 1'b0;
               in_ready_reg  <= 1'b1;
            end
         endcase
      end
   end

`ifdef BSLU_ZERO_FLAG_EN
   logic zero_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         zero_reg <= 1'b1;
      end else if (state_reg == ST_IDLE && in_valid) begin
         zero_reg <= 1'b1;
      end else if (state_reg == ST_RUN) begin
         zero_reg <= zero_reg & (slice_z == 8'h00);
      end
   end

   assign zero = zero_reg;
`endif

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign result    = result_reg;

endmodule

// File: tb/tb_byte_serial_logic_unit.sv
// Directed bench for byte_serial_logic_unit: vector table plus handshake corner sequences.
module tb_byte_serial_logic_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
`ifdef BSLU_ZERO_FLAG_EN
   logic        zero;
`endif

   int n_vec = 0;
   int n_err = 0;

   byte_serial_logic_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
`ifdef BSLU_ZERO_FLAG_EN
      ,
      .zero      (zero)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_result;
      logic        exp_zero;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one request, wait for the result with a bounded wait, check latency and value.
   task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] exp_r, input logic exp_z);
      int lat;
      @(negedge clk);
      check({name, " in_ready"}, 32'(in_ready), 32'd1);
      in_valid  = 1'b1;
      op        = o;
      a         = va;
      b         = vb;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      op = 3'(($urandom_range(0, 7)));
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check({name, " latency"}, 32'(lat), 32'd4);
      check({name, " result"}, result, exp_r);
`ifdef BSLU_ZERO_FLAG_EN
      check({name, " zero"}, 32'(zero), 32'(exp_z));
`else
      if (exp_z === 1'bx) $display("unused");
`endif
      $display("op=%b a=%h b=%h -> result=%h (expect %h) latency=%0d", o, va, vb, result, exp_r, lat);
      @(posedge clk);
      @(negedge clk);
      check({name, " idle in_ready"}, 32'(in_ready), 32'd1);
      check({name, " idle out_valid"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] held;
      logic [31:0] exp_q[$];
      logic [31:0] exp_v;
      int last_acc;
      int n_pop;
      int lat;

      vecs[0]  = '{3'b000, 32'h0F0F_00FF, 32'hFFFF_0F0F, 32'h0F0F_000F, 1'b0};
      vecs[1]  = '{3'b100, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 1'b1};
      vecs[2]  = '{3'b011, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
      vecs[3]  = '{3'b001, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0};
      vecs[4]  = '{3'b010, 32'h1234_5678, 32'hFFFF_0000, 32'hEDCB_5678, 1'b0};
      vecs[5]  = '{3'b101, 32'hCAFE_BABE, 32'h0000_0000, 32'hCAFE_BABE, 1'b0};
      vecs[6]  = '{3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
      vecs[7]  = '{3'b111, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0000_0000, 1'b1};
      vecs[8]  = '{3'b100, 32'h0F0F_00FF, 32'hFFFF_FFFF, 32'hF0F0_FF00, 1'b0};
      vecs[9]  = '{3'b000, 32'hFF00_FF00, 32'h00FF_00FF, 32'h0000_0000, 1'b1};
      vecs[10] = '{3'b001, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1'b0};
      vecs[11] = '{3'b011, 32'h00FF_FFFF, 32'h0000_0000, 32'hFF00_0000, 1'b0};

      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      op = 3'b000;
      a = 32'h0;
      b = 32'h0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset result", result, 32'h0);
`ifdef BSLU_ZERO_FLAG_EN
      check("reset zero", 32'(zero), 32'd1);
`endif
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].exp_result, vecs[i].exp_zero);
      end

      // Result held with out_ready low; new requests during DONE are ignored.
      @(negedge clk);
      in_valid = 1'b1; op = 3'b010; a = 32'h1234_5678; b = 32'hFFFF_0000; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; op = 3'b000;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); lat++; @(negedge clk);
      end
      check("hold latency", 32'(lat), 32'd4);
      held = 32'hEDCB_5678;
      for (int i = 0; i < 10; i++) begin
         check("hold out_valid", 32'(out_valid), 32'd1);
         check("hold in_ready", 32'(in_ready), 32'd0);
         check("hold result", result, held);
         @(negedge clk);
      end
      $display("hold: result=%h for 10 cycles", result);
      out_ready = 1'b1;
      @(negedge clk);
      check("release in_ready", 32'(in_ready), 32'd1);
      check("release out_valid", 32'(out_valid), 32'd0);
      in_valid = 1'b0;

      // Back-to-back with in_valid held high and operand A changing every cycle.
      op = 3'b010; b = 32'h0F0F_0F0F; in_valid = 1'b1; out_ready = 1'b1;
      last_acc = -1;
      n_pop = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         a = 32'h1111_1111 * 32'(cyc + 1);
         if (in_ready) begin
            if (last_acc >= 0) check("b2b spacing", 32'(cyc - last_acc), 32'd6);
            exp_q.push_back(a ^ b);
            last_acc = cyc;
         end
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("b2b unexpected result", result, 32'hx);
            end else begin
               exp_v = exp_q.pop_front();
               check("b2b result", result, exp_v);
               $display("b2b: result=%h (expect %h)", result, exp_v);
            end
            n_pop++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("b2b results", 32'(n_pop), 32'd5);

      // Reset while byte 2 of an OR is being written.
      @(negedge clk);
      in_valid = 1'b1; op = 3'b001; a = 32'h1234_5678; b = 32'h8765_4321;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrun rst out_valid", 32'(out_valid), 32'd0);
      check("midrun rst in_ready", 32'(in_ready), 32'd1);
      check("midrun rst result", result, 32'h0);
      $display("reset during RUN: result=%h in_ready=%b", result, in_ready);
      run_op("post-reset", 3'b001, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got hang expected finish");
      $fatal(1);
   end

endmodule
